// File: rtl/maze_mover.sv
// Grid mover: turns button rising edges into one-cell moves, looks the target
// cell up in an external wall map and holds off further input for a cooldown.
module maze_mover #(
  parameter logic [8:0]  MAX_X    = 9'd31,
  parameter logic [8:0]  MAX_Y    = 9'd31,
  parameter logic [23:0] COOLDOWN = 24'd2500000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [1:0]  game_state,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic [8:0]  goal_x,
  input  logic [8:0]  goal_y,
  output logic        wall_rd,
  output logic [8:0]  wall_addr_x,
  output logic [8:0]  wall_addr_y,
  input  logic        wall_q,
  output logic [8:0]  pos_x,
  output logic [8:0]  pos_y,
  output logic        arrived,
  output logic        bump,
  output logic [15:0] move_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, COOL} state_t;

  state_t       state_reg, state_next;
  logic [23:0]  cool_cnt_reg, cool_cnt_next;
  logic [8:0]   pos_x_reg, pos_x_next, pos_y_reg, pos_y_next;
  logic [8:0]   addr_x_reg, addr_x_next, addr_y_reg, addr_y_next;
  logic [15:0]  move_cnt_reg, move_cnt_next;
  logic         arrived_reg, arrived_next;
  logic         bump_reg, bump_next;

  // Bit order {up, down, left, right}; bit 3 has the highest priority.
  logic [3:0]   btn_now, btn_lvl_reg, btn_prev_reg, edge_vec;
  logic [9:0]   tgt_x, tgt_y;
  logic         playing, accept, off_map;

  assign btn_now = {btn_up, btn_down, btn_left, btn_right};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_edge
      assign edge_vec[gi] = btn_lvl_reg[gi] & ~btn_prev_reg[gi];
    end
  endgenerate

  // Decrementing from 0 wraps to 10'h3FF, which the range check also rejects.
  always_comb begin
    tgt_x = {1'b0, pos_x_reg};
    tgt_y = {1'b0, pos_y_reg};
    if (edge_vec[3])      tgt_y = {1'b0, pos_y_reg} - 10'd1;
    else if (edge_vec[2]) tgt_y = {1'b0, pos_y_reg} + 10'd1;
    else if (edge_vec[1]) tgt_x = {1'b0, pos_x_reg} - 10'd1;
    else if (edge_vec[0]) tgt_x = {1'b0, pos_x_reg} + 10'd1;
    off_map = (tgt_x > {1'b0, MAX_X}) || (tgt_y > {1'b0, MAX_Y});
  end

  assign playing     = (game_state == 2'b10);
  assign accept      = (state_reg == IDLE) && playing && !arrived_reg && (|edge_vec);
  // The lookup is issued in the accepting cycle so wall_q lands in WAIT.
  assign wall_rd     = accept && !off_map;
  assign wall_addr_x = wall_rd ? tgt_x[8:0] : addr_x_reg;
  assign wall_addr_y = wall_rd ? tgt_y[8:0] : addr_y_reg;

  always_comb begin
    state_next    = state_reg;
    cool_cnt_next = cool_cnt_reg;
    pos_x_next    = pos_x_reg;
    pos_y_next    = pos_y_reg;
    addr_x_next   = addr_x_reg;
    addr_y_next   = addr_y_reg;
    move_cnt_next = move_cnt_reg;
    bump_next     = 1'b0;
    arrived_next  = game_state[1] && (pos_x_reg == goal_x) && (pos_y_reg == goal_y);
    if (game_state == 2'b01) begin
      state_next    = IDLE;
      cool_cnt_next = '0;
      pos_x_next    = 9'd1;
      pos_y_next    = 9'd1;
      move_cnt_next = '0;
      arrived_next  = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            cool_cnt_next = '0;
            if (off_map) begin
              bump_next  = 1'b1;
              state_next = COOL;
            end else begin
              addr_x_next = tgt_x[8:0];
              addr_y_next = tgt_y[8:0];
              state_next  = WAIT;
            end
          end
        end
        WAIT: begin
          if (!playing) begin
            state_next = IDLE;
          end else begin
            state_next    = COOL;
            cool_cnt_next = '0;
            if (wall_q) begin
              bump_next = 1'b1;
            end else begin
              pos_x_next = addr_x_reg;
              pos_y_next = addr_y_reg;
              if (move_cnt_reg != 16'hFFFF) move_cnt_next = move_cnt_reg + 16'd1;
            end
          end
        end
        COOL: begin
          if (!playing || (cool_cnt_reg >= COOLDOWN - 24'd1)) begin
            state_next    = IDLE;
            cool_cnt_next = '0;
          end else begin
            cool_cnt_next = cool_cnt_reg + 24'd1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg    <= IDLE;
      cool_cnt_reg <= '0;
      pos_x_reg    <= 9'd1;
      pos_y_reg    <= 9'd1;
      addr_x_reg   <= '0;
      addr_y_reg   <= '0;
      move_cnt_reg <= '0;
      arrived_reg  <= 1'b0;
      bump_reg     <= 1'b0;
      btn_lvl_reg  <= '0;
      btn_prev_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cool_cnt_reg <= cool_cnt_next;
      pos_x_reg    <= pos_x_next;
      pos_y_reg    <= pos_y_next;
      addr_x_reg   <= addr_x_next;
      addr_y_reg   <= addr_y_next;
      move_cnt_reg <= move_cnt_next;
      arrived_reg  <= arrived_next;
      bump_reg     <= bump_next;
      btn_lvl_reg  <= btn_now;
      btn_prev_reg <= btn_lvl_reg;
    end
  end

  assign pos_x    = pos_x_reg;
  assign pos_y    = pos_y_reg;
  assign move_cnt = move_cnt_reg;
  assign arrived  = arrived_reg;
  assign bump     = bump_reg;

endmodule
